// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: control/redirect inputs in, registered PC and RAS occupancy out.
// The master drives the controls; the slave (pc_gen) owns pc_out and ras_count.
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic            stall;
    logic            trap;
    logic [XLEN-1:0] trap_vec;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            is_compressed;
    logic            fetch_call;
    logic            fetch_ret;
    logic [XLEN-1:0] pc_out;
    logic [CW-1:0]   ras_count;

    modport master (
        output stall, trap, trap_vec, redirect, redirect_pc,
        output is_compressed, fetch_call, fetch_ret,
        input  pc_out, ras_count
    );

    modport slave (
        input  stall, trap, trap_vec, redirect, redirect_pc,
        input  is_compressed, fetch_call, fetch_ret,
        output pc_out, ras_count
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator: +2/+4 sequential advance, trap/redirect override, optional
// return-address stack enabled by defining PC_RAS_EN (default build has no RAS, ras_count tied to 0).
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    pc_gen_if.slave bus
);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] seq_pc;

    assign step   = bus.is_compressed ? XLEN'(2) : XLEN'(4);
    assign seq_pc = pc_q + step;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            has_entry;

    // Explicit wrap so non-power-of-two depths stay inside the array.
    assign ptr_inc   = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_dec   = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - 1'b1;
    assign has_entry = (cnt_q != '0);

    always_comb begin
        pc_d  = pc_q;
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (bus.trap) begin
            pc_d = {bus.trap_vec[XLEN-1:1], 1'b0};
        end else if (bus.redirect) begin
            pc_d = {bus.redirect_pc[XLEN-1:1], 1'b0};
        end else if (!bus.stall) begin
            pc_d = seq_pc;
            if (bus.fetch_call && bus.fetch_ret && has_entry) begin
                // Co-routine swap: jump to the saved address and replace it with our own.
                pc_d         = ras_q[ptr_q];
                ras_d[ptr_q] = seq_pc;
            end else if (bus.fetch_call) begin
                ras_d[ptr_inc] = seq_pc;
                ptr_d          = ptr_inc;
                if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
            end else if (bus.fetch_ret && has_entry) begin
                pc_d  = ras_q[ptr_q];
                ptr_d = ptr_dec;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack contents survive reset; only the occupancy is cleared.
    always_ff @(posedge clk) begin
        if (!rst) ras_q <= ras_d;
    end

    assign bus.ras_count = cnt_q;
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = bus.fetch_call ^ bus.fetch_ret;

    always_comb begin
        pc_d = pc_q;
        if (bus.trap) begin
            pc_d = {bus.trap_vec[XLEN-1:1], 1'b0};
        end else if (bus.redirect) begin
            pc_d = {bus.redirect_pc[XLEN-1:1], 1'b0};
        end else if (!bus.stall) begin
            pc_d = seq_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_VEC;
        else     pc_q <= pc_d;
    end

    assign bus.ras_count = '0;
`endif

    assign bus.pc_out = pc_q;
endmodule
